// File: rtl/alu_arbiter_if.sv
// Bundle of request, response and shared-ALU signals for alu_arbiter.
// slave is the arbiter's view; master is the requesters + ALU side.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 3
);
  logic             req0_valid, req0_ready;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic [SEL_W-1:0] req0_sel;
  logic             req1_valid, req1_ready;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [SEL_W-1:0] req1_sel;
  logic             rsp0_valid, rsp0_ready, rsp0_zero;
  logic [WIDTH-1:0] rsp0_result;
  logic             rsp1_valid, rsp1_ready, rsp1_zero;
  logic [WIDTH-1:0] rsp1_result;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [SEL_W-1:0] alu_sel;
  logic             alu_zero;
  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel, req1_valid, req1_a, req1_b, req1_sel,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero, rsp1_valid, rsp1_result, rsp1_zero,
    input  rsp0_ready, rsp1_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_out, alu_zero,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel, req1_valid, req1_a, req1_b, req1_sel,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero, rsp1_valid, rsp1_result, rsp1_zero,
    output rsp0_ready, rsp1_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_out, alu_zero,
    input  busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters;
// one op in flight: IDLE (grant) -> EXEC (drive ALU) -> RESP (return result).
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t                      state, nxt;
  logic                        last_grant, owner;
  logic [WIDTH-1:0]            a_q, b_q;
  logic [SEL_W-1:0]            sel_q;
  logic [1:0][WIDTH-1:0]       res_q;
  logic [1:0]                  zero_q;
  logic [1:0]                  req_v, grant, rsp_rdy, rsp_v;
  logic [1:0][WIDTH-1:0]       req_a, req_b;
  logic [1:0][SEL_W-1:0]       req_sel;

  assign req_v   = {bus.req1_valid, bus.req0_valid};
  assign req_a   = {bus.req1_a, bus.req0_a};
  assign req_b   = {bus.req1_b, bus.req0_b};
  assign req_sel = {bus.req1_sel, bus.req0_sel};
  assign rsp_rdy = {bus.rsp1_ready, bus.rsp0_ready};

  always_comb begin
    nxt   = state;
    grant = '0;
    rsp_v = '0;
    case (state)
      IDLE: begin
        // On contention the requester that did not win the last accept goes.
        grant[0] = req_v[0] & (~req_v[1] | last_grant);
        grant[1] = req_v[1] & (~req_v[0] | ~last_grant);
        if (|grant) nxt = EXEC;
      end
      EXEC: nxt = RESP;
      RESP: begin
        rsp_v[owner] = 1'b1;
        if (rsp_rdy[owner]) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= '0;
      res_q      <= '0;
      zero_q     <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && |grant) begin
        owner      <= grant[1];
        last_grant <= grant[1];
        a_q        <= req_a[grant[1]];
        b_q        <= req_b[grant[1]];
        sel_q      <= req_sel[grant[1]];
      end
      if (state == EXEC) begin
        res_q[owner]  <= bus.alu_out;
        zero_q[owner] <= bus.alu_zero;
      end
    end
  end

  assign bus.req0_ready  = grant[0];
  assign bus.req1_ready  = grant[1];
  assign bus.rsp0_valid  = rsp_v[0];
  assign bus.rsp1_valid  = rsp_v[1];
  assign bus.rsp0_result = res_q[0];
  assign bus.rsp1_result = res_q[1];
  assign bus.rsp0_zero   = zero_q[0];
  assign bus.rsp1_zero   = zero_q[1];
  // The ALU only sees operands during EXEC so its inputs stay quiet otherwise.
  assign bus.alu_a       = (state == EXEC) ? a_q   : '0;
  assign bus.alu_b       = (state == EXEC) ? b_q   : '0;
  assign bus.alu_sel     = (state == EXEC) ? sel_q : '0;
  assign bus.busy        = (state != IDLE);
endmodule
